// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
// Owner tag of the pending response and the D-side request bundle.
package mem_arb_pkg;

  localparam int ARB_COLS       = 4;
  localparam int ARB_COL_BITS   = 8;
  localparam int ARB_ADDR_BITS  = 5;
  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_DATA_BITS  = ARB_COLS * ARB_COL_BITS;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ARB_ADDR_BITS-1:0] addr;
    logic [ARB_COLS-1:0]      we;
    logic [ARB_DATA_BITS-1:0] data;
  } d_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and load/store.
// D wins ties unless the fetch side has been starved too long.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_en,
  input  logic i_ivalid,
  input  logic i_dvalid,
  input  logic i_starve,
  output logic o_grant_i,
  output logic o_grant_d
);

  always_comb begin
    o_grant_i = 1'b0;
    o_grant_d = 1'b0;
    if (i_en) begin
      unique case (1'b1)
        i_ivalid & i_dvalid & i_starve:  o_grant_i = 1'b1;
        i_ivalid & i_dvalid & !i_starve: o_grant_d = 1'b1;
        i_ivalid & !i_dvalid:            o_grant_i = 1'b1;
        !i_ivalid & i_dvalid:            o_grant_d = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one read-first byte-write RAM between fetch (I) and LSU (D).
// One response slot, no skid buffer: a stalled response blocks new grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int COLS       = ARB_COLS,
  parameter int COL_BITS   = ARB_COL_BITS,
  parameter int ADDR_BITS  = ARB_ADDR_BITS,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  localparam int DATA_BITS = COLS * COL_BITS
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  output logic                 i_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_BITS-1:0] i_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [ADDR_BITS-1:0] d_req_addr,
  input  logic [COLS-1:0]      d_req_we,
  input  logic [DATA_BITS-1:0] d_req_data,
  output logic                 d_rsp_valid,
  input  logic                 d_rsp_ready,
  output logic [DATA_BITS-1:0] d_rsp_data,
  output logic                 ram_en,
  output logic [COLS-1:0]      ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_data_w,
  input  logic [DATA_BITS-1:0] ram_data_r
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  logic          r_rsp_pend;
  owner_e        r_rsp_owner;
  logic [CW-1:0] r_starve_cnt;

  logic   w_slot_free;
  logic   w_arb_en;
  logic   w_starve;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   w_grant;
  d_req_t w_dreq;

  assign w_dreq = '{addr: d_req_addr, we: d_req_we, data: d_req_data};

  assign w_slot_free = !r_rsp_pend ||
    ((r_rsp_owner == OWN_D) ? d_rsp_ready : i_rsp_ready);
  assign w_arb_en = rst_n & w_slot_free;
  assign w_starve = (r_starve_cnt == STARVE_TOP);

  mem_arb_pick u_pick (
    .i_en      (w_arb_en),
    .i_ivalid  (i_req_valid),
    .i_dvalid  (d_req_valid),
    .i_starve  (w_starve),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d)
  );

  assign w_grant     = w_grant_i | w_grant_d;
  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  assign ram_en     = w_grant;
  assign ram_addr   = w_grant_d ? w_dreq.addr : i_req_addr;
  assign ram_we     = w_grant_d ? w_dreq.we : '0;
  assign ram_data_w = w_dreq.data;

  // RAM output register holds while ram_en=0, so data is stall-stable
  assign i_rsp_valid = r_rsp_pend & (r_rsp_owner == OWN_I);
  assign d_rsp_valid = r_rsp_pend & (r_rsp_owner == OWN_D);
  assign i_rsp_data  = ram_data_r;
  assign d_rsp_data  = ram_data_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_pend   <= 1'b0;
      r_rsp_owner  <= OWN_I;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_rsp_pend  <= 1'b1;
        r_rsp_owner <= w_grant_d ? OWN_D : OWN_I;
      end else if (w_slot_free) begin
        r_rsp_pend <= 1'b0;
      end
      if (w_grant_i || (w_grant_d && !i_req_valid)) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && !w_starve) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule
